multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the single-issue RISC-V core. It fetches each instruction from instruction memory over a req/ack handshake and registers it. It decodes the instruction into the field buses consumed by the combinational ALU and register file, then strobes register-file writeback of the ALU's `rd_val`. It owns the 8-bit `PC`, detects unsupported opcodes and ECALL, and halts.

## Interface
- `PC_STEP`, 4: byte increment applied to `PC` per retired instruction.
- `CNT_W`, 16: width of retired-instruction counter.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: level; leaves IDLE when high.
- `imem_req` out 1: fetch request.
- `imem_addr` out 8: fetch address, always equals `PC`.
- `imem_ack` in 1: `imem_data` valid this cycle.
- `imem_data` in 32: instruction word.
- `PC` out 8: program counter, to ALU (AUIPC).
- `opcode` out 7: instr[6:0].
- `funct3` out 3: instr[14:12].
- `funct7` out 7: instr[31:25].
- `imm` out 12: immediate to ALU.
- `rs1_addr` out 5: instr[19:15].
- `rs2_addr` out 5: instr[24:20].
- `rd_addr` out 5: instr[11:7].
- `rf_we` out 1: register-file write strobe; regfile captures ALU `rd_val`.
- `halted` out 1: in HALT state.
- `illegal` out 1: sticky; the halt was caused by an unsupported opcode.
- `retired` out CNT_W: count of written-back instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE: `PC`=0. `start`=1 moves to FETCH.
- FETCH: `imem_req`=1 held until `imem_ack`. On ack, `imem_data` is latched into the instruction register (IR) and the FSM moves to DECODE. `imem_req` deasserts the cycle after ack.
- DECODE: all field outputs are registered from IR. Opcode check:
  - Supported opcodes are 0110011, 0010011, 0110111, 0010111; these go to EXECUTE.
  - IR == 32'h00000073 (ECALL) goes to HALT with `illegal`=0.
  - Any other opcode goes to HALT with `illegal`=1.
- Immediate selection:
  - I-type: `imm`=instr[31:20].
  - U-type: `imm`=instr[31:20]. This is the upper 12 bits of the U immediate; the core supports LUI/AUIPC immediates of 12 bits only.
- EXECUTE: one cycle for the ALU inputs to settle. Fields are held.
- WRITEBACK:
  - `rf_we`=1 for exactly one cycle, unless `rd_addr`==0, in which case `rf_we`=0.
  - `retired`+1, wrapping at 2^CNT_W.
  - `PC` += PC_STEP, modulo 256; 8'hFC wraps to 8'h00.
  - Next state is FETCH.
- HALT: terminal. All strobes are 0 and `PC`/fields are frozen. Exit only via `rst`. `start` is ignored.
- `halted`=1 only in HALT.

## Timing
- Reset (async, `rst`=0) sets state IDLE and drives:
  - `PC`=0, `imem_req`=0, `rf_we`=0, `halted`=0, `illegal`=0, `retired`=0.
  - All field outputs and IR to 0.
- Reset mid-operation, including while `imem_req`=1 or `rf_we`=1, takes effect immediately with no completion of the in-flight instruction.
- Minimum 4 cycles per instruction, when `imem_ack` arrives in the first FETCH cycle: FETCH, DECODE, EXECUTE, WRITEBACK. Each extra ack wait cycle adds 1.
- `start` sampled high at edge N puts the FSM in FETCH after edge N, so `imem_req`=1 in cycle N+1.
- Field outputs change only on the DECODE→EXECUTE edge. They are stable through EXECUTE and WRITEBACK.
- `PC` updates on the edge leaving WRITEBACK. The ALU sees the instruction's own `PC` during EXECUTE and WRITEBACK.
- `imem_ack` while `imem_req`=0 is ignored.

## Test plan
- Reset and start:
  - Assert `rst`=0 mid-FETCH → all outputs return to reset values.
  - Release, then `start`=1 with zero-wait ack of 32'h00500093 (ADDI x1,x0,5):
    - `rf_we` pulses in cycle 4 with `rd_addr`=1 and `imm`=12'h005.
    - `PC`=4 afterward and `retired`=1.
- Wait states: ack delayed 3 cycles → `imem_req` held 4 cycles, instruction completes in 7 cycles, `imem_addr` constant throughout.
- x0 destination: 32'h00100013 (ADDI x0,x0,1) → `rf_we` stays 0, but `PC` still advances and `retired` still increments.
- PC wrap: run 64 R-type instructions (ADD x3,x1,x2 = 32'h002081B3) → `PC` goes 8'hFC → 8'h00, `retired`=64.
- Halts:
  - 32'h00000073 → HALT with `halted`=1, `illegal`=0, and `PC` unchanged.
  - Opcode 7'b0000011 (load) → `halted`=1, `illegal`=1.
  - `start` pulses afterward have no effect.
- U-type: 32'hABC00537 (LUI x10) → `opcode`=7'b0110111, `imm`=12'hABC, `rd_addr`=10, `rf_we` pulse.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/execute/writeback sequencer for the core.
// Owns PC, the instruction register, decoded field buses and halt status.
//
// Ports:
//   clk, rst         clock, async active-low reset
//   start            level; leaves IDLE when high
//   imem_req/addr    fetch request and address (addr == PC)
//   imem_ack/data    fetch response, data valid while ack high
//   PC               program counter (ALU AUIPC operand)
//   opcode..rd_addr  registered instruction fields and immediate
//   rf_we            one-cycle register-file write strobe
//   halted, illegal  halt status; illegal marks an unsupported opcode
//   retired          count of written-back instructions
module multicycle_control #(
   parameter int unsigned PC_STEP = 4,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             imem_req,
   output logic [7:0]       imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_data,
   output logic [7:0]       PC,
   output logic [6:0]       opcode,
   output logic [2:0]       funct3,
   output logic [6:0]       funct7,
   output logic [11:0]      imm,
   output logic [4:0]       rs1_addr,
   output logic [4:0]       rs2_addr,
   output logic [4:0]       rd_addr,
   output logic             rf_we,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALT
   } state_t;

   state_t      state;
   logic [31:0] ir;

   logic [6:0]  ir_op;
   logic        is_r;
   logic        is_i;
   logic        is_lui;
   logic        is_auipc;
   logic        op_ok;
   logic        is_ecall;
   logic [11:0] imm_d;

   assign ir_op    = ir[6:0];
   assign is_r     = (ir_op == 7'b0110011);
   assign is_i     = (ir_op == 7'b0010011);
   assign is_lui   = (ir_op == 7'b0110111);
   assign is_auipc = (ir_op == 7'b0010111);
   assign op_ok    = is_r | is_i | is_lui | is_auipc;
   assign is_ecall = (ir == 32'h0000_0073);

   // I-type and U-type both take instr[31:20]; U-type only carries
   // the top 12 bits of its immediate. R-type has no immediate.
   always_comb begin
      imm_d = '0;
      if (is_i | is_lui | is_auipc)
         imm_d = ir[31:20];
   end

   assign imem_addr = PC;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         ir       <= '0;
         PC       <= '0;
         imem_req <= 1'b0;
         opcode   <= '0;
         funct3   <= '0;
         funct7   <= '0;
         imm      <= '0;
         rs1_addr <= '0;
         rs2_addr <= '0;
         rd_addr  <= '0;
         rf_we    <= 1'b0;
         halted   <= 1'b0;
         illegal  <= 1'b0;
         retired  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_FETCH;
                  imem_req <= 1'b1;
               end
            end
            S_FETCH: begin
               if (imem_ack) begin
                  ir       <= imem_data;
                  imem_req <= 1'b0;
                  state    <= S_DECODE;
               end
            end
            S_DECODE: begin
               // Fields only move when the instruction will execute,
               // so a halt leaves the previous instruction visible.
               if (op_ok) begin
                  opcode   <= ir[6:0];
                  rd_addr  <= ir[11:7];
                  funct3   <= ir[14:12];
                  rs1_addr <= ir[19:15];
                  rs2_addr <= ir[24:20];
                  funct7   <= ir[31:25];
                  imm      <= imm_d;
                  state    <= S_EXECUTE;
               end else begin
                  halted   <= 1'b1;
                  illegal  <= ~is_ecall;
                  state    <= S_HALT;
               end
            end
            S_EXECUTE: begin
               // x0 is hardwired zero: suppress the strobe.
               rf_we <= |rd_addr;
               state <= S_WRITEBACK;
            end
            S_WRITEBACK: begin
               rf_we    <= 1'b0;
               PC       <= PC + 8'(PC_STEP);
               retired  <= retired + CNT_W'(1);
               imem_req <= 1'b1;
               state    <= S_FETCH;
            end
            S_HALT: begin
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized and directed bench for the sequencer.
// Compares against a per-instruction model of PC, retired count and fields.
module tb_multicycle_control;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic [7:0]  PC;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [11:0] imm;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [4:0]  rd_addr;
   logic        rf_we;
   logic        halted;
   logic        illegal;
   logic [15:0] retired;

   int n_pass;
   int n_total;

   // reference model state
   int m_pc;
   int m_ret;
   logic [31:0] m_last;

   multicycle_control #(
      .PC_STEP(4),
      .CNT_W  (16)
   ) dut (
      .clk      (clk),
      .rst      (rst_n),
      .start    (start),
      .imem_req (imem_req),
      .imem_addr(imem_addr),
      .imem_ack (imem_ack),
      .imem_data(imem_data),
      .PC       (PC),
      .opcode   (opcode),
      .funct3   (funct3),
      .funct7   (funct7),
      .imm      (imm),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rd_addr  (rd_addr),
      .rf_we    (rf_we),
      .halted   (halted),
      .illegal  (illegal),
      .retired  (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit m_supported(input logic [31:0] ins);
      logic [6:0] op;
      op = ins[6:0];
      return op == 7'b0110011 || op == 7'b0010011 ||
             op == 7'b0110111 || op == 7'b0010111;
   endfunction

   function automatic bit m_has_imm(input logic [31:0] ins);
      logic [6:0] op;
      op = ins[6:0];
      return op == 7'b0010011 || op == 7'b0110111 ||
             op == 7'b0010111;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b0;
      imem_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_pc = 0;
      m_ret = 0;
      m_last = '0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Serves one fetch with `dly` wait cycles and observes the instruction
   // until the next fetch request or the halt. Called on a negedge.
   task automatic exec_instr(
      input  logic [31:0] ins,
      input  int          dly,
      output int          req_n,
      output int          tot_n,
      output int          we_n,
      output bit          addr_ok,
      output logic [7:0]  pc_seen,
      output logic [31:0] f_seen,
      output logic [11:0] imm_seen,
      output bit          tmo
   );
      int k;
      int guard;
      bit acked;
      logic [7:0] a0;
      k = 0;
      guard = 0;
      acked = 0;
      tmo = 0;
      req_n = 0;
      tot_n = 0;
      we_n = 0;
      addr_ok = 1;
      pc_seen = '0;
      f_seen = '0;
      imm_seen = '0;
      while (!imem_req && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!imem_req) begin
         tmo = 1;
         return;
      end
      a0 = imem_addr;
      guard = 0;
      while (guard < 40) begin
         if (acked && (imem_req || halted))
            break;
         tot_n++;
         if (imem_req) begin
            req_n++;
            if (imem_addr !== a0)
               addr_ok = 0;
         end
         if (rf_we === 1'b1)
            we_n++;
         if (!acked) begin
            if (k == dly) begin
               imem_ack = 1'b1;
               imem_data = ins;
               acked = 1;
            end
            k++;
         end else begin
            imem_ack = 1'b0;
            pc_seen = PC;
            f_seen = {funct7, rs2_addr, rs1_addr,
                      funct3, rd_addr, opcode};
            imm_seen = imm;
         end
         @(negedge clk);
         guard++;
      end
      imem_ack = 1'b0;
      if (guard >= 40)
         tmo = 1;
   endtask

   task automatic test_reset();
      logic [63:0] got;
      #1;
      got = {PC, imem_req, rf_we, halted, illegal, retired,
             opcode, funct3, funct7, rs1_addr, rs2_addr, rd_addr};
      n_total++;
      if (got !== '0 || imm !== '0)
         $display("FAIL reset_vals: got %h imm %h want 0", got, imm);
      else
         n_pass++;
   endtask

   task automatic test_idle_ack();
      // acks without a request must not start anything
      rst_n = 1'b1;
      @(negedge clk);
      imem_ack = 1'b1;
      imem_data = 32'h00500093;
      repeat (3) @(negedge clk);
      imem_ack = 1'b0;
      n_total++;
      if (imem_req !== 1'b0 || retired !== 16'd0 || PC !== 8'd0)
         $display("FAIL idle_ack: req %b ret %0d pc %0d want 0 0 0",
                  imem_req, retired, PC);
      else
         n_pass++;
   endtask

   task automatic test_reset_midfetch();
      logic [31:0] got;
      do_start();
      n_total++;
      if (imem_req !== 1'b1)
         $display("FAIL start_req: got %b want 1", imem_req);
      else
         n_pass++;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      got = {PC, imem_req, rf_we, halted, illegal, retired, 4'h0};
      n_total++;
      if (got !== '0)
         $display("FAIL midfetch_reset: got %h want 0", got);
      else
         n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      m_pc = 0;
      m_ret = 0;
   endtask

   task automatic test_addi();
      int rq, tt, we;
      bit aok, tmo;
      logic [7:0] pcs;
      logic [31:0] fs;
      logic [11:0] is;
      do_start();
      exec_instr(32'h00500093, 0, rq, tt, we, aok, pcs, fs, is, tmo);
      m_pc = (m_pc + 4) % 256;
      m_ret++;
      n_total++;
      if (tmo || tt != 4 || we != 1)
         $display("FAIL addi_timing: tmo %0d cyc %0d we %0d want 0 4 1",
                  tmo, tt, we);
      else
         n_pass++;
      n_total++;
      if (fs[11:7] !== 5'd1 || is !== 12'h005)
         $display("FAIL addi_fields: rd %0d imm %h want 1 005",
                  fs[11:7], is);
      else
         n_pass++;
      n_total++;
      if (PC !== 8'(m_pc) || retired !== 16'(m_ret))
         $display("FAIL addi_pc: pc %0d ret %0d want %0d %0d",
                  PC, retired, m_pc, m_ret);
      else
         n_pass++;
   endtask

   task automatic test_wait_states();
      int rq, tt, we;
      bit aok, tmo;
      logic [7:0] pcs;
      logic [31:0] fs;
      logic [11:0] is;
      exec_instr(32'h00A00113, 3, rq, tt, we, aok, pcs, fs, is, tmo);
      n_total++;
      if (tmo || rq != 4 || tt != 7 || !aok)
         $display("FAIL wait3: tmo %0d req %0d cyc %0d aok %0d want 0 4 7 1",
                  tmo, rq, tt, aok);
      else
         n_pass++;
      n_total++;
      if (pcs !== 8'(m_pc))
         $display("FAIL wait3_pc_exec: got %0d want %0d", pcs, m_pc);
      else
         n_pass++;
      m_pc = (m_pc + 4) % 256;
      m_ret++;
   endtask

   task automatic test_x0();
      int rq, tt, we;
      bit aok, tmo;
      logic [7:0] pcs;
      logic [31:0] fs;
      logic [11:0] is;
      exec_instr(32'h00100013, 0, rq, tt, we, aok, pcs, fs, is, tmo);
      m_pc = (m_pc + 4) % 256;
      m_ret++;
      n_total++;
      if (tmo || we != 0 || tt != 4)
         $display("FAIL x0_we: tmo %0d we %0d cyc %0d want 0 0 4",
                  tmo, we, tt);
      else
         n_pass++;
      n_total++;
      if (PC !== 8'(m_pc) || retired !== 16'(m_ret))
         $display("FAIL x0_pc: pc %0d ret %0d want %0d %0d",
                  PC, retired, m_pc, m_ret);
      else
         n_pass++;
   endtask

   task automatic test_random();
      logic [6:0] ops [4];
      int rq, tt, we, dly, exp_we;
      bit aok, tmo;
      logic [7:0] pcs;
      logic [31:0] fs, r, ins;
      logic [11:0] is;
      ops[0] = 7'b0110011;
      ops[1] = 7'b0010011;
      ops[2] = 7'b0110111;
      ops[3] = 7'b0010111;
      for (int n = 0; n < 40; n++) begin
         r = $urandom();
         ins = {r[31:7], ops[$urandom_range(0, 3)]};
         dly = $urandom_range(0, 2);
         exec_instr(ins, dly, rq, tt, we, aok, pcs, fs, is, tmo);
         exp_we = (ins[11:7] != 5'd0) ? 1 : 0;
         n_total++;
         if (tmo || rq != dly + 1 || tt != dly + 4 || we != exp_we || !aok)
            $display("FAIL rnd_timing[%0d]: req %0d cyc %0d we %0d want %0d %0d %0d",
                     n, rq, tt, we, dly + 1, dly + 4, exp_we);
         else
            n_pass++;
         n_total++;
         if (fs !== ins || pcs !== 8'(m_pc))
            $display("FAIL rnd_fields[%0d]: f %h pc %0d want %h %0d",
                     n, fs, pcs, ins, m_pc);
         else
            n_pass++;
         if (m_has_imm(ins)) begin
            n_total++;
            if (is !== ins[31:20])
               $display("FAIL rnd_imm[%0d]: got %h want %h",
                        n, is, ins[31:20]);
            else
               n_pass++;
         end
         m_pc = (m_pc + 4) % 256;
         m_ret++;
         m_last = ins;
         n_total++;
         if (PC !== 8'(m_pc) || retired !== 16'(m_ret))
            $display("FAIL rnd_pc[%0d]: pc %0d ret %0d want %0d %0d",
                     n, PC, retired, m_pc, m_ret);
         else
            n_pass++;
      end
   endtask

   task automatic test_lui();
      int rq, tt, we;
      bit aok, tmo;
      logic [7:0] pcs;
      logic [31:0] fs;
      logic [11:0] is;
      exec_instr(32'hABC00537, 1, rq, tt, we, aok, pcs, fs, is, tmo);
      m_pc = (m_pc + 4) % 256;
      m_ret++;
      m_last = 32'hABC00537;
      n_total++;
      if (fs[6:0] !== 7'b0110111 || is !== 12'hABC || fs[11:7] !== 5'd10)
         $display("FAIL lui_fields: op %b imm %h rd %0d want 0110111 abc 10",
                  fs[6:0], is, fs[11:7]);
      else
         n_pass++;
      n_total++;
      if (tmo || we != 1 || tt != 5)
         $display("FAIL lui_we: tmo %0d we %0d cyc %0d want 0 1 5",
                  tmo, we, tt);
      else
         n_pass++;
   endtask

   task automatic test_pc_wrap();
      int rq, tt, we;
      bit aok, tmo;
      logic [7:0] pcs;
      logic [31:0] fs;
      logic [11:0] is;
      int bad;
      bad = 0;
      do_reset();
      do_start();
      for (int n = 0; n < 64; n++) begin
         exec_instr(32'h002081B3, 0, rq, tt, we, aok, pcs, fs, is, tmo);
         if (tmo || tt != 4 || we != 1 || pcs !== 8'(m_pc))
            bad++;
         m_pc = (m_pc + 4) % 256;
         m_ret++;
         if (pcs === 8'hFC) begin
            n_total++;
            if (PC !== 8'h00)
               $display("FAIL pc_wrap_edge: got %h want 00", PC);
            else
               n_pass++;
         end
      end
      m_last = 32'h002081B3;
      n_total++;
      if (bad != 0)
         $display("FAIL add_loop: %0d bad instrs want 0", bad);
      else
         n_pass++;
      n_total++;
      if (PC !== 8'(m_pc) || retired !== 16'd64)
         $display("FAIL pc_wrap_end: pc %0d ret %0d want %0d 64",
                  PC, retired, m_pc);
      else
         n_pass++;
   endtask

   task automatic test_halt(input logic [31:0] ins, input string nm);
      int rq, tt, we;
      bit aok, tmo, exp_ill;
      logic [7:0] pcs;
      logic [31:0] fs, after;
      logic [11:0] is;
      exp_ill = !m_supported(ins) && ins != 32'h00000073;
      exec_instr(ins, 1, rq, tt, we, aok, pcs, fs, is, tmo);
      n_total++;
      if (tmo || tt != 3 || halted !== 1'b1 || illegal !== exp_ill)
         $display("FAIL %s_halt: tmo %0d cyc %0d h %b ill %b want 0 3 1 %b",
                  nm, tmo, tt, halted, illegal, exp_ill);
      else
         n_pass++;
      n_total++;
      if (PC !== 8'(m_pc) || retired !== 16'(m_ret))
         $display("FAIL %s_pc: pc %0d ret %0d want %0d %0d",
                  nm, PC, retired, m_pc, m_ret);
      else
         n_pass++;
      repeat (3) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
      end
      after = {funct7, rs2_addr, rs1_addr, funct3, rd_addr, opcode};
      n_total++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || rf_we !== 1'b0 ||
          PC !== 8'(m_pc) || after !== m_last)
         $display("FAIL %s_frozen: h %b req %b we %b pc %0d f %h want 1 0 0 %0d %h",
                  nm, halted, imem_req, rf_we, PC, after, m_pc, m_last);
      else
         n_pass++;
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      m_pc = 0;
      m_ret = 0;
      m_last = '0;
      rst_n = 1'b0;
      start = 1'b0;
      imem_ack = 1'b0;
      imem_data = '0;
      test_reset();
      @(negedge clk);
      test_idle_ack();
      test_reset_midfetch();
      test_addi();
      test_wait_states();
      test_x0();
      test_random();
      test_lui();
      test_halt(32'h00000073, "ecall");
      test_pc_wrap();
      test_halt(32'h00002083, "load");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
